// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard event path.
//   PS2_PREFIX_EXT / PS2_PREFIX_BRK : scancode prefix bytes folded by the decoder
//   ps2_evt_t                       : one decoded key event {extended, brk, code}
//   ps2_dec_state_t                 : prefix-decoder state
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef struct packed {
    logic       extended;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  localparam int unsigned PS2_EVT_W = $bits(ps2_evt_t);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_dec_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with a registered head word.
//   clk, reset  : clock, synchronous active-high reset
//   push, din   : write request and data (dropped when full and not popping)
//   pop         : advance head (ignored when empty)
//   flush       : empty the FIFO, discard same-cycle push/pop
//   dout        : registered head entry, holds last value when empty
//   valid       : registered not-empty
//   count       : registered number of stored entries, 0..DEPTH
//   overflow_c  : combinational pulse, push dropped because full
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             full_c, do_push, do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign full_c     = (count_q == CW'(DEPTH));
  assign do_pop     = pop & valid_q & ~flush;
  assign do_push    = push & ~flush & (~full_c | do_pop);
  assign overflow_c = push & ~flush & full_c & ~do_pop;

  // Next occupancy.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

  // Pointers, occupancy and registered head word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
      // Head comes from din when the FIFO is (or becomes) otherwise empty,
      // else from the entry behind the one being popped.
      if (do_push && (count_q == '0 || (do_pop && count_q == CW'(1))))
        dout_q <= din;
      else if (do_pop && count_q > CW'(1))
        dout_q <= mem[rd_q + AW'(1)];
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;
  assign count = count_q;

endmodule

// File: rtl/ps2_kbd_event_fifo.sv
// PS/2 scancode prefix decoder feeding an event FIFO, with sticky status.
//   clk, reset_i            : clock, synchronous active-high reset
//   ps2_code_i/strobe_i     : received byte and its one-cycle valid pulse
//   ps2_err_i               : receive error pulse, aborts any partial prefix
//   rd_i, flush_i, clr_i    : pop head, empty FIFO + reset decoder, clear sticky status
//   evt_o, valid_o, count_o : head event {ext, brk, code}, not-empty, occupancy
//   overflow_o, err_o       : sticky dropped-event / receive-error flags
//   err_cnt_o               : saturating receive-error count
module ps2_kbd_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic [7:0]               ps2_code_i,
  input  logic                     ps2_strobe_i,
  input  logic                     ps2_err_i,
  input  logic                     rd_i,
  input  logic                     flush_i,
  input  logic                     clr_i,
  output logic [PS2_EVT_W-1:0]     evt_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     err_o,
  output logic [ERR_CNT_W-1:0]     err_cnt_o
);

  ps2_dec_state_t       state_q, state_d;
  ps2_evt_t             evt_d;
  logic                 push_c;
  logic                 ovf_c;
  logic                 overflow_q, err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Decoder state register.
  always_ff @(posedge clk) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Prefix folding: prefixes move between states, any other byte emits an event.
  always_comb begin
    state_d      = state_q;
    push_c       = 1'b0;
    evt_d        = '0;
    evt_d.code   = ps2_code_i;
    if (ps2_err_i || flush_i) begin
      state_d = IDLE;
    end else if (ps2_strobe_i) begin
      if (ps2_code_i == PS2_PREFIX_EXT) begin
        state_d = (state_q == IDLE) ? EXT
                : (state_q == EXT)  ? EXT : EXT_BRK;
      end else if (ps2_code_i == PS2_PREFIX_BRK) begin
        state_d = (state_q == IDLE) ? BRK
                : (state_q == BRK)  ? BRK : EXT_BRK;
      end else begin
        push_c         = 1'b1;
        evt_d.extended = (state_q == EXT) || (state_q == EXT_BRK);
        evt_d.brk      = (state_q == BRK) || (state_q == EXT_BRK);
        state_d        = IDLE;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (PS2_EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset_i),
    .push       (push_c),
    .din        (evt_d),
    .pop        (rd_i),
    .flush      (flush_i),
    .dout       (evt_o),
    .valid      (valid_o),
    .count      (count_o),
    .overflow_c (ovf_c)
  );

  // Sticky status: a same-cycle set wins over clr_i.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      overflow_q <= ovf_c | (overflow_q & ~clr_i);
      err_q      <= ps2_err_i | (err_q & ~clr_i);
      if (clr_i)
        err_cnt_q <= ps2_err_i ? ERR_CNT_W'(1) : '0;
      else if (ps2_err_i && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign overflow_o = overflow_q;
  assign err_o      = err_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_ps2_kbd_event_fifo.sv
// Self-checking bench for ps2_kbd_event_fifo: decode table, scoreboard fill/drain, corner sequences.
module tb_ps2_kbd_event_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_i, ps2_strobe_i, ps2_err_i, rd_i, flush_i, clr_i;
  logic [7:0]    ps2_code_i;
  logic [9:0]    evt_o;
  logic          valid_o, overflow_o, err_o;
  logic [CW-1:0] count_o;
  logic [7:0]    err_cnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         n;
    logic [7:0] b [4];
    logic [9:0] exp;
  } vec_t;

  vec_t       vecs [10];
  logic [9:0] sb [$];

  ps2_kbd_event_fifo #(.DEPTH(DEPTH), .ERR_CNT_W(8)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .ps2_code_i   (ps2_code_i),
    .ps2_strobe_i (ps2_strobe_i),
    .ps2_err_i    (ps2_err_i),
    .rd_i         (rd_i),
    .flush_i      (flush_i),
    .clr_i        (clr_i),
    .evt_o        (evt_o),
    .valid_o      (valid_o),
    .count_o      (count_o),
    .overflow_o   (overflow_o),
    .err_o        (err_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] c);
    ps2_code_i = c; ps2_strobe_i = 1'b1;
    tick();
    ps2_strobe_i = 1'b0;
    tick();
  endtask

  task automatic pulse_err();
    ps2_err_i = 1'b1; tick(); ps2_err_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1; tick(); clr_i = 1'b0;
  endtask

  task automatic pop1();
    rd_i = 1'b1; tick(); rd_i = 1'b0;
  endtask

  task automatic set_vec(input int i, input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input logic [9:0] exp);
    vecs[i].n = n;
    vecs[i].b[0] = b0; vecs[i].b[1] = b1; vecs[i].b[2] = b2; vecs[i].b[3] = b3;
    vecs[i].exp = exp;
  endtask

  initial begin
    set_vec(0, 1, 8'h1C, 8'h00, 8'h00, 8'h00, 10'h01C);
    set_vec(1, 3, 8'hE0, 8'hF0, 8'h74, 8'h00, 10'h374);
    set_vec(2, 3, 8'hF0, 8'hE0, 8'h74, 8'h00, 10'h374);
    set_vec(3, 2, 8'hE0, 8'h75, 8'h00, 8'h00, 10'h275);
    set_vec(4, 2, 8'hF0, 8'h1C, 8'h00, 8'h00, 10'h11C);
    set_vec(5, 1, 8'hE1, 8'h00, 8'h00, 8'h00, 10'h0E1);
    set_vec(6, 3, 8'hE0, 8'hE0, 8'h6B, 8'h00, 10'h26B);
    set_vec(7, 3, 8'hF0, 8'hF0, 8'h12, 8'h00, 10'h112);
    set_vec(8, 4, 8'hE0, 8'hF0, 8'hF0, 8'h70, 10'h370);
    set_vec(9, 4, 8'hF0, 8'hE0, 8'hE0, 8'h00, 10'h300);

    reset_i = 1'b1; ps2_code_i = '0; ps2_strobe_i = 1'b0; ps2_err_i = 1'b0;
    rd_i = 1'b0; flush_i = 1'b0; clr_i = 1'b0;
    tick(); tick();
    reset_i = 1'b0;

    chk("reset valid",    32'(valid_o),    32'h0);
    chk("reset count",    32'(count_o),    32'h0);
    chk("reset evt",      32'(evt_o),      32'h0);
    chk("reset overflow", 32'(overflow_o), 32'h0);
    chk("reset err",      32'(err_o),      32'h0);
    chk("reset err_cnt",  32'(err_cnt_o),  32'h0);

    // Decode table: each sequence yields exactly one event.
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < vecs[v].n; i++) send(vecs[v].b[i]);
      chk($sformatf("vec%0d valid", v), 32'(valid_o), 32'h1);
      chk($sformatf("vec%0d count", v), 32'(count_o), 32'h1);
      chk($sformatf("vec%0d evt", v),   32'(evt_o),   32'(vecs[v].exp));
      pop1();
      chk($sformatf("vec%0d popped", v), 32'(valid_o), 32'h0);
    end

    // One-cycle latency from strobe to valid.
    ps2_code_i = 8'h2A; ps2_strobe_i = 1'b1; tick(); ps2_strobe_i = 1'b0;
    chk("latency valid", 32'(valid_o), 32'h1);
    chk("latency evt",   32'(evt_o),   32'h02A);
    pop1();

    // Read while empty is a no-op.
    pop1();
    chk("underflow count", 32'(count_o), 32'h0);
    chk("underflow valid", 32'(valid_o), 32'h0);

    // Error aborts a pending prefix.
    send(8'hE0);
    pulse_err();
    send(8'h74);
    chk("err evt",     32'(evt_o),     32'h074);
    chk("err flag",    32'(err_o),     32'h1);
    chk("err cnt",     32'(err_cnt_o), 32'h1);
    chk("err count",   32'(count_o),   32'h1);
    pop1();
    pulse_clr();
    chk("clr err",     32'(err_o),     32'h0);
    chk("clr err cnt", 32'(err_cnt_o), 32'h0);

    // Error and strobe together: byte discarded.
    ps2_code_i = 8'h33; ps2_strobe_i = 1'b1; ps2_err_i = 1'b1; tick();
    ps2_strobe_i = 1'b0; ps2_err_i = 1'b0; tick();
    chk("err+strobe count", 32'(count_o), 32'h0);
    // Clear and error together: error wins.
    clr_i = 1'b1; ps2_err_i = 1'b1; tick(); clr_i = 1'b0; ps2_err_i = 1'b0;
    chk("clr+err flag", 32'(err_o),     32'h1);
    chk("clr+err cnt",  32'(err_cnt_o), 32'h1);
    // Counter saturates.
    ps2_err_i = 1'b1; repeat (300) tick(); ps2_err_i = 1'b0;
    chk("err cnt sat", 32'(err_cnt_o), 32'hFF);
    pulse_clr();

    // Fill past full with the scoreboard tracking what should survive.
    for (int v = 1; v <= DEPTH + 1; v++) begin
      if (sb.size() < DEPTH) sb.push_back(10'(v));
      send(8'(v));
    end
    chk("full count",    32'(count_o),    32'(DEPTH));
    chk("full overflow", 32'(overflow_o), 32'h1);
    pulse_clr();
    chk("ovf cleared",   32'(overflow_o), 32'h0);

    // Push and pop together while full.
    chk("full head", 32'(evt_o), 32'(sb.pop_front()));
    sb.push_back(10'h022);
    ps2_code_i = 8'h22; ps2_strobe_i = 1'b1; rd_i = 1'b1; tick();
    ps2_strobe_i = 1'b0; rd_i = 1'b0;
    chk("full push+pop count", 32'(count_o),    32'(DEPTH));
    chk("full push+pop ovf",   32'(overflow_o), 32'h0);

    // Drain against the scoreboard, bounded.
    for (int k = 0; k < 2 * DEPTH && valid_o; k++) begin
      if (sb.size() == 0) begin
        chk("drain extra entry", 32'(evt_o), 32'h3FF);
        break;
      end
      chk($sformatf("drain %0d", k), 32'(evt_o), 32'(sb.pop_front()));
      pop1();
    end
    chk("drain left in sb", 32'(sb.size()), 32'h0);
    chk("drain valid",      32'(valid_o),   32'h0);

    // Push and pop together while empty: push lands.
    ps2_code_i = 8'h33; ps2_strobe_i = 1'b1; rd_i = 1'b1; tick();
    ps2_strobe_i = 1'b0; rd_i = 1'b0;
    chk("empty push+pop count", 32'(count_o), 32'h1);
    chk("empty push+pop evt",   32'(evt_o),   32'h033);

    // Flush with a same-cycle push after a pending prefix.
    send(8'h44);
    send(8'hE0);
    pulse_err();
    ps2_code_i = 8'h55; ps2_strobe_i = 1'b1; flush_i = 1'b1; tick();
    ps2_strobe_i = 1'b0; flush_i = 1'b0;
    chk("flush count", 32'(count_o), 32'h0);
    chk("flush valid", 32'(valid_o), 32'h0);
    chk("flush keeps err", 32'(err_o), 32'h1);
    send(8'hF0);
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    send(8'h1C);
    chk("after flush evt", 32'(evt_o), 32'h01C);
    chk("after flush count", 32'(count_o), 32'h1);

    // Reset in the middle of a break sequence.
    send(8'hF0);
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    chk("mid reset count", 32'(count_o), 32'h0);
    send(8'h1C);
    chk("post reset evt",      32'(evt_o),      32'h01C);
    chk("post reset count",    32'(count_o),    32'h1);
    chk("post reset err",      32'(err_o),      32'h0);
    chk("post reset err_cnt",  32'(err_cnt_o),  32'h0);
    chk("post reset overflow", 32'(overflow_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_event_fifo.md
Name: ps2_kbd_event_fifo

Overview:
- Sits between the PS/2 keyboard receiver (ps2kbd) and the SoC keyboard register port, in the clk domain.
- Consumes raw scancode bytes (code/strobe/err) and folds the 0xE0 (extended) and 0xF0 (break) prefixes into one event word per key.
- Buffers events in a first-word-fall-through FIFO so the CPU can poll without losing keystrokes.
- Reports overflow and receive errors through sticky flags.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ERR_CNT_W, 8, width of the saturating receive-error counter.

Ports:
- clk  in  1  system clock (pixel/CPU clock domain).
- reset_i  in  1  synchronous, active-high reset.
- ps2_code_i  in  8  received scancode byte; valid only when ps2_strobe_i=1.
- ps2_strobe_i  in  1  one-cycle pulse: ps2_code_i holds a good byte.
- ps2_err_i  in  1  one-cycle pulse: parity/framing error on the received byte.
- rd_i  in  1  pop the head event; ignored when valid_o=0.
- flush_i  in  1  empty the FIFO and return the decoder to IDLE.
- clr_i  in  1  clear overflow_o, err_o and err_cnt_o.
- evt_o  out  10  head event: [9]=extended, [8]=break, [7:0]=code.
- valid_o  out  1  FIFO not empty.
- count_o  out  $clog2(DEPTH)+1  number of stored events.
- overflow_o  out  1  sticky: an event was dropped because the FIFO was full.
- err_o  out  1  sticky: ps2_err_i seen.
- err_cnt_o  out  ERR_CNT_W  saturating count of ps2_err_i pulses.

Behaviour:
- Reset values: valid_o=0, count_o=0, evt_o=0, overflow_o=0, err_o=0, err_cnt_o=0; decoder in IDLE.
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions occur only when ps2_strobe_i=1.
  - IDLE: 0xE0 -> EXT; 0xF0 -> BRK; any other code -> push {0,0,code}, stay IDLE.
  - EXT: 0xF0 -> EXT_BRK; 0xE0 -> stay EXT (repeated prefix tolerated); other -> push {1,0,code} -> IDLE.
  - BRK: 0xE0 -> EXT_BRK (out-of-order prefix accepted); 0xF0 -> stay BRK; other -> push {0,1,code} -> IDLE.
  - EXT_BRK: 0xE0/0xF0 -> stay; other -> push {1,1,code} -> IDLE.
  - 0xE1 (Pause prefix) and all other bytes are treated as ordinary codes.
- Error handling, when ps2_err_i=1 (takes priority over ps2_strobe_i in the same cycle):
  - FSM -> IDLE; byte discarded; nothing pushed.
  - err_o <= 1; err_cnt_o increments and saturates at all-ones.
- FIFO latency: push on cycle N -> valid_o=1, evt_o and count_o updated on cycle N+1.
- evt_o always reflects the head entry (fall-through). When the FIFO is empty, evt_o holds its last value and is not meaningful.
- Pop: rd_i=1 with valid_o=1 advances the head on the next edge. rd_i with valid_o=0 is a no-op with no underflow.
- Full boundary:
  - Push while full with no pop -> event dropped, overflow_o <= 1, contents unchanged.
  - Push and pop in the same cycle while full -> both occur, count unchanged, no overflow.
- Empty boundary: push and pop in the same cycle while empty -> the pop is ignored and the push lands (count 0 -> 1).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count_o is tracked separately, range 0..DEPTH.
- flush_i: count=0, pointers=0, FSM -> IDLE on the next edge. A same-cycle push is discarded. Sticky flags are unaffected.
- clr_i: clears overflow_o, err_o and err_cnt_o. A same-cycle set event wins, so the flag reads 1 afterwards.
- reset_i asserted mid-sequence (e.g. after 0xE0, before the code) discards the partial prefix. The next byte after reset decodes from IDLE.

Decomposition:
- Package ps2_pkg:
  - constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0;
  - typedef ps2_evt_t, a packed struct {extended, brk, code[7:0]};
  - FSM state enum ps2_dec_state_t.
- Sub-module sync_fifo_fwft (params WIDTH, DEPTH) holds the storage, pointers, count and full/empty logic. It exposes push/pop/flush, full/empty and overflow-on-push-when-full.
- The top of this block holds the decoder FSM and the sticky flag logic.

Test Plan:
- Strobe 0x1C -> one cycle later valid_o=1, evt_o=10'h01C, count_o=1. Pulse rd_i -> valid_o=0.
- Strobe 0xE0, 0xF0, 0x74 (interleaved with idle cycles) -> exactly one event, evt_o=10'h374, count_o=1.
- Strobe 0xE0, then pulse ps2_err_i, then strobe 0x74 -> evt_o=10'h074, err_o=1, err_cnt_o=1. Pulse clr_i -> err_o=0, err_cnt_o=0.
- DEPTH=16: push 17 codes 0x01..0x11 with no reads -> count_o=16, overflow_o=1. Reading out yields 0x01..0x10 in order; 0x11 is lost.
- FIFO full: strobe 0x22 with rd_i=1 in the same cycle -> overflow_o stays 0, count_o=16, tail entry =10'h022.
- Strobe 0xF0, assert reset_i for 1 cycle, then strobe 0x1C -> evt_o=10'h01C (break bit clear), all flags 0.
